interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter: FRAME_DIV, default 833333, clock cycles per frame-timer period; legal range 2..1048575.
REQ-002 Port: CLK  input  1  single system clock; all logic on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: ENABLE  input  1  1 = new requests may be presented; 0 = sources still latched, no new IRQ raised.
REQ-005 Port: KBD_VALID  input  1  one-cycle strobe; new scancode present on KBD_CODE.
REQ-006 Port: KBD_CODE  input  8  keyboard scancode; sampled only when KBD_VALID=1.
REQ-007 Port: INT_IACK  input  1  processor acknowledge; one-cycle pulse.
REQ-008 Port: INT_IEND  input  1  processor end-of-service; one-cycle pulse.
REQ-009 Port: INT_IRQ  output  2  request code: 2'b00 frame timer, 2'b01 keyboard, 2'b11 none; 2'b10 never driven.
REQ-010 Port: KBD_KEY  output  8  scancode at keyboard queue head; 8'h00 when queue empty.
REQ-011 Port: FRAME_OVERRUN  output  1  sticky; a timer tick arrived while timer request already pending.
REQ-012 Port: KBD_OVERFLOW  output  1  sticky; a scancode was dropped because the queue was full.

Function
REQ-013 Frame counter: counts 0..FRAME_DIV-1, wraps to 0; the wrap cycle is the tick and sets timerPending next cycle.
REQ-014 Tick while timerPending=1 (and not cleared that cycle): no second request; FRAME_OVERRUN set to 1.
REQ-015 Keyboard queue: 4-entry FIFO, 3-bit count 0..4, 2-bit wrapping read/write pointers.
REQ-016 KBD_VALID with count<4: code written, count+1; with count=4 and no pop that cycle: code dropped, KBD_OVERFLOW set.
REQ-017 Push and pop in the same cycle: both performed, count unchanged, allowed even at count=4.
REQ-018 FSM states: IDLE, ASSERT, SERVICE, RELEASE; INT_IRQ=2'b11 in every state except ASSERT.
REQ-019 IDLE: if ENABLE=1 and timerPending=1 -> ASSERT with source=timer; else if ENABLE=1 and count>0 -> ASSERT with source=keyboard; else stay.
REQ-020 Priority: timer over keyboard; source latched on IDLE->ASSERT and held until return to IDLE.
REQ-021 ASSERT: INT_IRQ = latched source code, held stable until INT_IACK=1; ENABLE dropping in ASSERT does not withdraw the request.
REQ-022 INT_IACK in ASSERT -> SERVICE; same edge clears timerPending (timer) or pops FIFO head (keyboard).
REQ-023 KBD_KEY equals the popped code during the INT_IACK cycle, so the processor latches it on that cycle.
REQ-024 SERVICE: wait for INT_IEND; INT_IEND=1 -> RELEASE; no timeout.
REQ-025 RELEASE: one cycle, INT_IRQ=2'b11, unconditionally -> IDLE; guarantees an idle gap between back-to-back requests.
REQ-026 INT_IEND and INT_IACK in ASSERT on the same cycle: INT_IACK honoured, INT_IEND ignored.
REQ-027 INT_IACK outside ASSERT, or INT_IEND outside SERVICE: ignored, no state or queue change.
REQ-028 Tick on the same cycle as timer-source INT_IACK: pending cleared, then re-set; no overrun flagged.
REQ-029 Request latency: source pending in IDLE -> INT_IRQ valid on the next cycle.

Reset
REQ-030 RESET=1 at any clock edge, including mid-service: FSM=IDLE, frame counter=0, timerPending=0, FIFO empty with pointers at 0, FRAME_OVERRUN=0, KBD_OVERFLOW=0.
REQ-031 Output values in reset: INT_IRQ=2'b11, KBD_KEY=8'h00.
REQ-032 RESET has priority over all other inputs; a KBD_VALID on a reset cycle is discarded.

Verification
REQ-033 FRAME_DIV=10, ENABLE=1, no keys -> INT_IRQ=00 one cycle after tick; IACK -> 11; IEND -> RELEASE then IDLE; next request 10 cycles after previous tick.
REQ-034 Push 8'h20 -> INT_IRQ=01 and KBD_KEY=20 on the IACK cycle; queue empty afterwards, KBD_KEY=00.
REQ-035 Push 8'h11,22,33,44,55 without service -> KBD_OVERFLOW=1; four requests served in order 11,22,33,44; 55 never appears.
REQ-036 Tick and key pending together in IDLE -> timer served first (00), then keyboard (01) after the RELEASE gap.
REQ-037 Hold IACK low across two ticks -> FRAME_OVERRUN=1, exactly one timer request; RESET asserted in SERVICE -> IRQ=11, flags cleared next cycle.
REQ-038 ENABLE=0 with key queued -> INT_IRQ stays 11; ENABLE=1 -> INT_IRQ=01 on the next cycle.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: keyboard input, processor handshake, status.
// master = processor/keyboard side, slave = controller.
interface interrupt_controller_if;
   logic       ENABLE;
   logic       KBD_VALID;
   logic [7:0] KBD_CODE;
   logic       INT_IACK;
   logic       INT_IEND;
   logic [1:0] INT_IRQ;
   logic [7:0] KBD_KEY;
   logic       FRAME_OVERRUN;
   logic       KBD_OVERFLOW;

   modport master (
      output ENABLE, KBD_VALID, KBD_CODE, INT_IACK, INT_IEND,
      input  INT_IRQ, KBD_KEY, FRAME_OVERRUN, KBD_OVERFLOW
   );

   modport slave (
      input  ENABLE, KBD_VALID, KBD_CODE, INT_IACK, INT_IEND,
      output INT_IRQ, KBD_KEY, FRAME_OVERRUN, KBD_OVERFLOW
   );
endinterface

// File: rtl/interrupt_controller.sv
// Two-source interrupt controller: frame timer + 4-deep keyboard FIFO.
// Ports: CLK, RESET (sync, active-high), bus (slave modport).
module interrupt_controller #(
   parameter int FRAME_DIV = 833333
) (
   input  logic                  CLK,
   input  logic                  RESET,
   interrupt_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, ASSERT, SERVICE, RELEASE
   } state_t;

   localparam logic [19:0] LAST = 20'(FRAME_DIV - 1);

   state_t      state_q, state_d;
   logic        src_q, src_d;     // 0 = timer, 1 = keyboard
   logic [19:0] cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic        ovr_q, ovr_d;
   logic        kovf_q, kovf_d;
   logic [7:0]  mem_q [4];
   logic [7:0]  mem_d [4];
   logic [1:0]  rd_q, rd_d;
   logic [1:0]  wr_q, wr_d;
   logic [2:0]  fcnt_q, fcnt_d;

   logic tick, ack, clr, pop, push, full;

   always_comb begin
      tick = (cnt_q == LAST);
      ack  = (state_q == ASSERT) && bus.INT_IACK;
      clr  = ack && !src_q;
      pop  = ack && src_q;
      full = (fcnt_q == 3'd4);
      // A pop frees a slot in the same cycle, so a full queue still accepts
      push = bus.KBD_VALID && (!full || pop);

      cnt_d  = tick ? '0 : cnt_q + 20'd1;
      // Tick wins over a same-cycle clear: request re-arms, no overrun
      pend_d = tick | (pend_q & ~clr);
      ovr_d  = ovr_q | (tick & pend_q & ~clr);
      kovf_d = kovf_q | (bus.KBD_VALID & full & ~pop);

      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      fcnt_d = fcnt_q;
      if (push) begin
         mem_d[wr_q] = bus.KBD_CODE;
         wr_d        = wr_q + 2'd1;
      end
      if (pop) begin
         rd_d = rd_q + 2'd1;
      end
      unique case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + 3'd1;
         2'b01:   fcnt_d = fcnt_q - 3'd1;
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      unique case (state_q)
         IDLE: begin
            if (bus.ENABLE && pend_q) begin
               state_d = ASSERT;
               src_d   = 1'b0;
            end else if (bus.ENABLE && fcnt_q != 3'd0) begin
               state_d = ASSERT;
               src_d   = 1'b1;
            end
         end
         ASSERT: begin
            if (bus.INT_IACK) state_d = SERVICE;
         end
         SERVICE: begin
            if (bus.INT_IEND) state_d = RELEASE;
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         src_q   <= 1'b0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
         kovf_q  <= 1'b0;
         rd_q    <= '0;
         wr_q    <= '0;
         fcnt_q  <= '0;
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
         kovf_q  <= kovf_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         fcnt_q  <= fcnt_d;
         mem_q   <= mem_d;
      end
   end

   // Outputs forced idle while RESET is held, even before the first edge
   assign bus.INT_IRQ = (!RESET && state_q == ASSERT) ?
                        {1'b0, src_q} : 2'b11;
   assign bus.KBD_KEY = (RESET || fcnt_q == 3'd0) ?
                        8'h00 : mem_q[rd_q];
   assign bus.FRAME_OVERRUN = ovr_q;
   assign bus.KBD_OVERFLOW  = kovf_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller with FRAME_DIV=10: vector table,
// directed corner sequences and random traffic against a queue model.
module tb_interrupt_controller;

   localparam int DIV = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   interrupt_controller_if bus();

   interrupt_controller #(.FRAME_DIV(DIV)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   int n_run  = 0;
   int n_fail = 0;

   // Reference model: phase 0 idle, 1 requesting, 2 in service, 3 gap
   int  m_phase, m_src, m_cyc;
   bit  m_pend, m_ovr, m_kovf;
   byte unsigned m_q[$];

   typedef struct {
      logic       r, e, kv;
      logic [7:0] kc;
      logic       ia, ie;
      logic [1:0] irq;
      logic [7:0] key;
      logic       ovr, kovf;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic logic [1:0] m_irq();
      return (m_phase == 1) ? 2'(m_src) : 2'b11;
   endfunction

   function automatic logic [7:0] m_key();
      return (m_q.size() > 0) ? m_q[0] : 8'h00;
   endfunction

   task automatic model(input logic r, e, kv, input logic [7:0] kc,
                        input logic ia, ie);
      bit tick, ack, clr, pop;
      int nph, nsrc;
      if (r) begin
         m_phase = 0; m_src = 0; m_cyc = 0;
         m_pend = 0; m_ovr = 0; m_kovf = 0;
         m_q.delete();
      end else begin
         tick  = (m_cyc == DIV - 1);
         m_cyc = (m_cyc + 1) % DIV;
         ack   = (m_phase == 1) && ia;
         clr   = ack && m_src == 0;
         pop   = ack && m_src == 1;
         nph   = m_phase;
         nsrc  = m_src;
         case (m_phase)
            0: if (e && m_pend) begin nph = 1; nsrc = 0; end
               else if (e && m_q.size() > 0) begin nph = 1; nsrc = 1; end
            1: if (ia) nph = 2;
            2: if (ie) nph = 3;
            default: nph = 0;
         endcase
         if (tick && m_pend && !clr) m_ovr = 1;
         if (tick) m_pend = 1;
         else if (clr) m_pend = 0;
         if (pop) void'(m_q.pop_front());
         if (kv) begin
            if (m_q.size() < 4) m_q.push_back(kc);
            else m_kovf = 1;
         end
         m_phase = nph;
         m_src   = nsrc;
      end
   endtask

   task automatic step(input logic r, e, kv, input logic [7:0] kc,
                       input logic ia, ie);
      rst           = r;
      bus.ENABLE    = e;
      bus.KBD_VALID = kv;
      bus.KBD_CODE  = kc;
      bus.INT_IACK  = ia;
      bus.INT_IEND  = ie;
      model(r, e, kv, kc, ia, ie);
      @(posedge clk);
      #1;
      chk("m_irq", 32'(bus.INT_IRQ), 32'(m_irq()));
      chk("m_key", 32'(bus.KBD_KEY), 32'(m_key()));
      chk("m_ovr", 32'(bus.FRAME_OVERRUN), 32'(m_ovr));
      chk("m_kovf", 32'(bus.KBD_OVERFLOW), 32'(m_kovf));
   endtask

   task automatic add(input logic r, e, kv, input logic [7:0] kc,
                      input logic ia, ie, input logic [1:0] irq,
                      input logic [7:0] key, input logic ovr, kovf);
      vec_t v;
      v.r = r; v.e = e; v.kv = kv; v.kc = kc; v.ia = ia; v.ie = ie;
      v.irq = irq; v.key = key; v.ovr = ovr; v.kovf = kovf;
      tbl.push_back(v);
   endtask

   initial begin
      int reqs;
      logic [1:0] prev;

      bus.ENABLE = 0; bus.KBD_VALID = 0; bus.KBD_CODE = 0;
      bus.INT_IACK = 0; bus.INT_IEND = 0;
      #1;
      chk("reset_irq", 32'(bus.INT_IRQ), 32'h3);
      chk("reset_key", 32'(bus.KBD_KEY), 32'h0);

      //  r e kv code ia ie | irq key  ovr kovf
      add(1,0,0,8'h00,0,0, 2'b11,8'h00,0,0);
      add(0,1,1,8'h20,0,0, 2'b11,8'h20,0,0);
      add(0,1,0,8'h00,0,0, 2'b01,8'h20,0,0);
      add(0,1,0,8'h00,1,0, 2'b11,8'h00,0,0);
      add(0,1,0,8'h00,0,1, 2'b11,8'h00,0,0);
      add(0,1,0,8'h00,0,0, 2'b11,8'h00,0,0);
      add(0,1,1,8'h11,0,0, 2'b11,8'h11,0,0);
      add(0,0,1,8'h22,0,0, 2'b11,8'h11,0,0);
      add(0,0,1,8'h33,0,0, 2'b11,8'h11,0,0);
      add(0,0,1,8'h44,0,0, 2'b11,8'h11,0,0);
      add(0,0,1,8'h55,0,0, 2'b11,8'h11,0,1);
      add(0,0,0,8'h00,0,0, 2'b11,8'h11,0,1);
      add(0,1,0,8'h00,0,0, 2'b00,8'h11,0,1);
      add(0,1,0,8'h00,1,0, 2'b11,8'h11,0,1);
      add(0,1,0,8'h00,0,1, 2'b11,8'h11,0,1);
      add(0,1,0,8'h00,0,0, 2'b11,8'h11,0,1);
      add(0,1,0,8'h00,0,0, 2'b01,8'h11,0,1);
      add(0,1,0,8'h00,1,1, 2'b11,8'h22,0,1);
      add(0,1,0,8'h00,1,0, 2'b11,8'h22,0,1);
      add(0,1,0,8'h00,0,1, 2'b11,8'h22,0,1);
      add(0,1,0,8'h00,0,0, 2'b11,8'h22,0,1);
      add(0,1,0,8'h00,0,0, 2'b00,8'h22,0,1);
      add(0,1,0,8'h00,1,0, 2'b11,8'h22,0,1);
      add(0,1,0,8'h00,0,1, 2'b11,8'h22,0,1);
      add(0,1,0,8'h00,0,0, 2'b11,8'h22,0,1);
      add(0,1,0,8'h00,0,0, 2'b01,8'h22,0,1);
      add(0,0,0,8'h00,1,0, 2'b11,8'h33,0,1);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].e, tbl[i].kv, tbl[i].kc,
              tbl[i].ia, tbl[i].ie);
         chk($sformatf("tbl%0d_irq", i), 32'(bus.INT_IRQ),
             32'(tbl[i].irq));
         chk($sformatf("tbl%0d_key", i), 32'(bus.KBD_KEY),
             32'(tbl[i].key));
         chk($sformatf("tbl%0d_ovr", i), 32'(bus.FRAME_OVERRUN),
             32'(tbl[i].ovr));
         chk($sformatf("tbl%0d_kovf", i), 32'(bus.KBD_OVERFLOW),
             32'(tbl[i].kovf));
      end

      // Timer request left unacknowledged across two more ticks
      step(1,0,0,8'h00,0,0);
      reqs = 0;
      prev = 2'b11;
      for (int k = 0; k < 31; k++) begin
         step(0,1,0,8'h00,0,0);
         if (bus.INT_IRQ == 2'b00 && prev != 2'b00) reqs++;
         prev = bus.INT_IRQ;
      end
      chk("ovr_flag", 32'(bus.FRAME_OVERRUN), 32'h1);
      chk("ovr_reqs", 32'(reqs), 32'h1);
      chk("ovr_irq_held", 32'(bus.INT_IRQ), 32'h0);
      step(0,1,1,8'h77,1,0);
      chk("svc_irq", 32'(bus.INT_IRQ), 32'h3);
      step(0,1,1,8'h78,0,0);
      step(1,1,1,8'h79,0,0);
      chk("rst_svc_irq", 32'(bus.INT_IRQ), 32'h3);
      chk("rst_svc_ovr", 32'(bus.FRAME_OVERRUN), 32'h0);
      chk("rst_svc_kovf", 32'(bus.KBD_OVERFLOW), 32'h0);
      chk("rst_svc_key", 32'(bus.KBD_KEY), 32'h0);
      step(0,1,0,8'h00,0,0);
      chk("rst_drop_irq", 32'(bus.INT_IRQ), 32'h3);

      // ENABLE gating with a key queued
      step(1,0,0,8'h00,0,0);
      step(0,0,1,8'h5A,0,0);
      for (int k = 0; k < 3; k++) step(0,0,0,8'h00,0,0);
      chk("en0_irq", 32'(bus.INT_IRQ), 32'h3);
      step(0,1,0,8'h00,0,0);
      chk("en1_irq", 32'(bus.INT_IRQ), 32'h1);
      chk("en1_key", 32'(bus.KBD_KEY), 32'h5A);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0,
              8'($urandom),
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
